timer_bank: RTL and testbench
=============================

// Module: timer_bank
// PURPOSE
//  Parametrised bank of CH independent prescaled timer/counters with free-run, periodic-compare and one-shot modes,
//  sticky overflow/match flags, per-channel interrupt outputs and a registered read port. Replaces the fixed four
//  timer_counter instances in blastit_main. Sits between clk and the MCU PIO/bus bridge.
// PARAMETERS
//  CH      4   number of timer channels (1..16)
//  CH_BITS 2   width of channel select, >= clog2(CH)
//  M_BITS  32  prescaler modulus width
//  N_BITS  24  event counter / compare width
// PORTS
//  clk        in   1            system clock, all state on posedge
//  reset_n    in   1            asynchronous active-low reset
//  wr         in   1            write strobe, one cycle
//  wr_ch      in   CH_BITS      channel addressed by write
//  wr_sel     in   2            0=M (prescale modulus), 1=CMP, 2=CTRL, 3=CLEAR
//  wr_data    in   M_BITS       write data; CMP uses [N_BITS-1:0], CTRL uses [3:0], CLEAR uses [1:0]
//  rd         in   1            read strobe, one cycle
//  rd_ch      in   CH_BITS      channel addressed by read
//  rd_valid   out  1            pulses one cycle after rd
//  rd_data    out  N_BITS+2     {match, of, counter} of rd_ch, sampled at rd
//  done_tick  out  CH           one-cycle pulse per channel on wrap (FREE) or compare hit (PERIODIC/ONESHOT)
//  irq        out  CH           level: irq[i] = ie[i] & (match[i] | of[i])
// BEHAVIOUR
//  - Reset: all m, cmp, prescaler, counter = 0; ctrl = 0 (disabled, FREE, ie=0); flags = 0; rd_valid=0,
//    rd_data=0, done_tick=0, irq=0. Reset mid-operation aborts everything immediately (async).
//  - CTRL bits: [0] en, [2:1] mode (00 FREE, 01 PERIODIC, 10 ONESHOT, 11 treated as FREE), [3] ie.
//  - Per channel, each cycle with en=1: tick = (p >= m_eff-1), m_eff = max(m,1); on tick p<=0 else p<=p+1.
//    en=0: p and counter hold. Writing CTRL with en 0->1 clears p (counter untouched).
//  - On tick, state by mode:
//    FREE: counter+1 modulo 2^N_BITS; on all-ones -> 0 set of, pulse done_tick.
//    PERIODIC: counter==cmp -> counter<=0, set match, pulse done_tick; else counter+1 (wraps, sets of, no done_tick).
//    ONESHOT: counter==cmp -> set match, pulse done_tick, clear en, counter holds at cmp; else as PERIODIC.
//  - done_tick asserted the cycle after the tick edge (registered); counter update visible same cycle.
//  - Writes take effect next edge. M write while running applies immediately; if p >= new m-1 the next cycle ticks.
//    CMP write below current counter: no match until counter wraps round (of set on wrap).
//  - CLEAR: wr_data[0] clears counter and p; wr_data[1] clears match and of. Clear beats a same-cycle tick/set.
//  - Flags are sticky; only CLEAR or reset clears them.
//  - wr/rd with channel >= CH: write ignored; read returns rd_data=0, rd_valid still pulses.
//  - rd latency 1: rd_data registered from state at the rd edge (pre-update of a same-cycle tick); holds until next rd.
//  - Simultaneous wr and rd to same channel: read returns pre-write values.
//  - Counter arithmetic unsigned, N_BITS wide, no saturation; prescaler M_BITS wide.
// TESTING
//  1 Reset: reset_n=0 mid-count -> all outputs 0 asynchronously; release -> counters idle at 0.
//  2 FREE, CH0 m=3, en=1: counter increments every 3 clocks; N_BITS=4 build: after 48 clocks counter=0, of=1,
//    one done_tick pulse.
//  3 PERIODIC, CH1 m=1 cmp=5 ie=1: counter 0..5 then 0, done_tick every 6 cycles, irq[1]=1 after first hit;
//    CLEAR data=2 -> irq drops next cycle, counter keeps running.
//  4 ONESHOT, CH2 m=2 cmp=4: counter stops at 4, en reads 0, single done_tick, match=1; re-enable via CTRL resumes.
//  5 Collision: CLEAR data=3 on the exact cycle of a compare hit -> counter=0, match=0, no done_tick.
//  6 Read port: rd rd_ch=CH (out of range) -> rd_valid=1, rd_data=0; rd rd_ch=1 -> {match,of,counter} 1 cycle later.

Source files
------------

// File: rtl/timer_bank.sv
// Bank of CH prescaled timer/counters: free-run, periodic-compare, one-shot.
// Sticky match/overflow flags, per-channel irq and a registered read port.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   wr, wr_ch, wr_sel  write strobe, channel, register (0=M 1=CMP 2=CTRL 3=CLEAR)
//   wr_data            write data (CMP [N_BITS-1:0], CTRL [3:0], CLEAR [1:0])
//   rd, rd_ch          read strobe and channel
//   rd_valid, rd_data  one cycle after rd: {match, of, counter} of rd_ch
//   done_tick          per-channel one-cycle event pulse
//   irq                per-channel level interrupt, ie & (match | of)

module timer_bank #(
   parameter int CH      = 4,
   parameter int CH_BITS = 2,
   parameter int M_BITS  = 32,
   parameter int N_BITS  = 24
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr,
   input  logic [CH_BITS-1:0] wr_ch,
   input  logic [1:0]        wr_sel,
   input  logic [M_BITS-1:0] wr_data,
   input  logic              rd,
   input  logic [CH_BITS-1:0] rd_ch,
   output logic              rd_valid,
   output logic [N_BITS+1:0] rd_data,
   output logic [CH-1:0]     done_tick,
   output logic [CH-1:0]     irq
);

   localparam logic [1:0] MODE_PER = 2'b01;
   localparam logic [1:0] MODE_ONE = 2'b10;

   localparam logic [1:0] SEL_M   = 2'd0;
   localparam logic [1:0] SEL_CMP = 2'd1;
   localparam logic [1:0] SEL_CTL = 2'd2;
   localparam logic [1:0] SEL_CLR = 2'd3;

   logic [N_BITS+1:0] stat [CH];

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [M_BITS-1:0] m_q,    m_d;
      logic [M_BITS-1:0] p_q,    p_d;
      logic [N_BITS-1:0] cmp_q,  cmp_d;
      logic [N_BITS-1:0] cnt_q,  cnt_d;
      logic [3:0]        ctrl_q, ctrl_d;
      logic              match_q, match_d;
      logic              of_q,   of_d;
      logic              done_q, done_d;

      logic              sel;
      logic              en;
      logic [1:0]        mode;
      logic              is_per;
      logic              is_one;
      logic [M_BITS-1:0] m_lim;
      logic              tick;
      logic              hit;
      logic              wrap;

      assign sel    = wr && (wr_ch == CH_BITS'(i));
      assign en     = ctrl_q[0];
      assign mode   = ctrl_q[2:1];
      assign is_per = (mode == MODE_PER);
      assign is_one = (mode == MODE_ONE);

      // m = 0 behaves like m = 1: tick every enabled cycle.
      assign m_lim = (m_q == '0) ? '0 : m_q - M_BITS'(1);
      assign tick  = en && (p_q >= m_lim);
      assign hit   = (is_per || is_one) && (cnt_q == cmp_q);
      assign wrap  = &cnt_q;

      always_comb begin
         m_d     = m_q;
         p_d     = p_q;
         cmp_d   = cmp_q;
         cnt_d   = cnt_q;
         ctrl_d  = ctrl_q;
         match_d = match_q;
         of_d    = of_q;
         done_d  = 1'b0;

         if (tick) begin
            p_d = '0;
            if (hit) begin
               match_d = 1'b1;
               done_d  = 1'b1;
               if (is_one) begin
                  ctrl_d[0] = 1'b0;
               end else begin
                  cnt_d = '0;
               end
            end else begin
               cnt_d = cnt_q + N_BITS'(1);
               if (wrap) begin
                  of_d = 1'b1;
                  if (!(is_per || is_one)) begin
                     done_d = 1'b1;
                  end
               end
            end
         end else if (en) begin
            p_d = p_q + M_BITS'(1);
         end

         if (sel) begin
            unique case (wr_sel)
               SEL_M: begin
                  m_d = wr_data;
               end
               SEL_CMP: begin
                  cmp_d = wr_data[N_BITS-1:0];
               end
               SEL_CTL: begin
                  ctrl_d = wr_data[3:0];
                  if (!en && wr_data[0]) begin
                     p_d = '0;
                  end
               end
               SEL_CLR: begin
                  // A counter clear cancels the whole tick event,
                  // including the one-shot disable and flag sets.
                  if (wr_data[0]) begin
                     cnt_d   = '0;
                     p_d     = '0;
                     done_d  = 1'b0;
                     ctrl_d  = ctrl_q;
                     match_d = match_q;
                     of_d    = of_q;
                  end
                  if (wr_data[1]) begin
                     match_d = 1'b0;
                     of_d    = 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            m_q     <= '0;
            p_q     <= '0;
            cmp_q   <= '0;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            match_q <= 1'b0;
            of_q    <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            m_q     <= m_d;
            p_q     <= p_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            match_q <= match_d;
            of_q    <= of_d;
            done_q  <= done_d;
         end
      end

      assign stat[i]      = {match_q, of_q, cnt_q};
      assign done_tick[i] = done_q;
      assign irq[i]       = ctrl_q[3] & (match_q | of_q);
   end

   logic              rd_valid_q;
   logic [N_BITS+1:0] rd_data_q, rd_data_d;

   // Out-of-range channels match no index and read back as zero.
   always_comb begin
      rd_data_d = '0;
      for (int i = 0; i < CH; i++) begin
         if (rd_ch == CH_BITS'(i)) begin
            rd_data_d = stat[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd;
         if (rd) begin
            rd_data_q <= rd_data_d;
         end
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank (CH=4, N_BITS=4 build).
// Reads push expected rd_data; a negedge monitor pops on rd_valid.

module tb_timer_bank;

   localparam int CH = 4;
   localparam int CB = 3;
   localparam int MB = 8;
   localparam int NB = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          wr = 1'b0;
   logic [CB-1:0] wr_ch = '0;
   logic [1:0]    wr_sel = '0;
   logic [MB-1:0] wr_data = '0;
   logic          rd = 1'b0;
   logic [CB-1:0] rd_ch = '0;
   logic          rd_valid;
   logic [NB+1:0] rd_data;
   logic [CH-1:0] done_tick;
   logic [CH-1:0] irq;

   timer_bank #(
      .CH(CH), .CH_BITS(CB), .M_BITS(MB), .N_BITS(NB)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .wr(wr), .wr_ch(wr_ch), .wr_sel(wr_sel), .wr_data(wr_data),
      .rd(rd), .rd_ch(rd_ch),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .done_tick(done_tick), .irq(irq)
   );

   always #5 clk = ~clk;

   int            n_tests = 0;
   int            n_fail = 0;
   logic [NB+1:0] exp_q [$];
   int            done_cnt [CH] = '{default: 0};
   int            d0, d1, d2, d3;

   always @(negedge clk) begin
      logic [NB+1:0] e;
      for (int i = 0; i < CH; i++)
         if (done_tick[i] === 1'b1) done_cnt[i]++;
      if (rd_valid === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: got rd_data=%h, required no read pending", rd_data);
         end else begin
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               n_fail++;
               $display("FAIL rd_data: got %h, required %h", rd_data, e);
            end
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic step(int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wreg(int ch, int sel, int data);
      wr = 1'b1;
      wr_ch = CB'(ch);
      wr_sel = 2'(sel);
      wr_data = MB'(data);
      step(1);
      wr = 1'b0;
   endtask

   task automatic rreg(int ch, logic [NB+1:0] e);
      rd = 1'b1;
      rd_ch = CB'(ch);
      exp_q.push_back(e);
      step(1);
      rd = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      // reset state
      step(1);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_done", 32'(done_tick), 0);
      chk("rst_irq", 32'(irq), 0);
      reset_n = 1'b1;
      step(2);
      rreg(0, 6'h00);

      // FREE ch0, m=3: 16 increments in 48 clocks -> wrap
      d0 = done_cnt[0];
      wreg(0, 0, 3);
      wreg(0, 2, 1);
      step(47);
      rreg(0, 6'h0F);
      rreg(0, 6'h10);
      wreg(0, 2, 0);
      chk("free_done", 32'(done_cnt[0] - d0), 1);
      chk("free_irq", 32'(irq), 0);

      // PERIODIC ch1, m=1 cmp=5 ie=1
      d1 = done_cnt[1];
      wreg(1, 0, 1);
      wreg(1, 1, 5);
      wreg(1, 2, 'hB);
      step(5);
      chk("per_irq_pre", 32'(irq[1]), 0);
      step(1);
      chk("per_irq_hit", 32'(irq[1]), 1);
      chk("per_done1", 32'(done_cnt[1] - d1), 1);
      step(6);
      chk("per_done2", 32'(done_cnt[1] - d1), 2);
      wreg(1, 3, 2);
      chk("per_irq_clr", 32'(irq[1]), 0);
      rreg(1, 6'h01);
      wreg(1, 2, 0);
      chk("per_done_end", 32'(done_cnt[1] - d1), 2);

      // ONESHOT ch2, m=2 cmp=4
      d2 = done_cnt[2];
      wreg(2, 0, 2);
      wreg(2, 1, 4);
      wreg(2, 2, 5);
      step(20);
      rreg(2, 6'h24);
      chk("one_done", 32'(done_cnt[2] - d2), 1);
      wreg(2, 3, 3);
      wreg(2, 2, 5);
      step(5);
      rreg(2, 6'h02);
      step(10);
      chk("one_done_re", 32'(done_cnt[2] - d2), 2);
      rreg(2, 6'h24);

      // collision: CLEAR=3 on the compare-hit edge
      d3 = done_cnt[3];
      wreg(3, 0, 1);
      wreg(3, 1, 3);
      wreg(3, 2, 3);
      step(3);
      wreg(3, 3, 3);
      rreg(3, 6'h00);
      chk("col_done", 32'(done_cnt[3] - d3), 0);
      rreg(3, 6'h01);
      wreg(3, 2, 0);

      // read port: out of range, plain, simultaneous wr/rd
      rreg(4, 6'h00);
      rreg(7, 6'h00);
      rreg(1, 6'h03);
      wr = 1'b1;
      wr_ch = 3'd1;
      wr_sel = 2'd3;
      wr_data = 8'd1;
      rreg(1, 6'h03);
      wr = 1'b0;
      rreg(1, 6'h00);
      wreg(4, 3, 3);
      rreg(0, 6'h10);

      // async reset mid-operation
      wreg(0, 2, 9);
      chk("pre_rst_irq", 32'(irq), 1);
      chk("pre_rst_rd", 32'(rd_data), 'h10);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_irq", 32'(irq), 0);
      chk("arst_rd_data", 32'(rd_data), 0);
      chk("arst_rd_valid", 32'(rd_valid), 0);
      chk("arst_done", 32'(done_tick), 0);
      step(1);
      reset_n = 1'b1;
      step(4);
      rreg(0, 6'h00);
      rreg(2, 6'h00);
      step(2);
      chk("sb_empty", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
